execute_stage: RTL and testbench

//  EX stage of the 5-stage pipeline: takes ID/EX operands and control, computes the ALU

---
 rtl/execute_stage.sv | 167 ++++++++++++++++
 tb/tb_execute_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage of the 5-stage pipeline: single-cycle ALU ops plus a one-bit-per-cycle shift-add
// multiplier, registered into the EX/MEM latch that feeds the memory stage.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DX_valid,
  input  logic [3:0]        DX_ALUctr,
  input  logic              DX_ALUSrc,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] DX_B,
  input  logic [15:0]       DX_imm,
  input  logic [DATA_W-1:0] DX_MD,
  input  logic [RD_W-1:0]   DX_RD,
  input  logic              DX_MemtoReg,
  input  logic              DX_RegWrite,
  input  logic              DX_MemRead,
  input  logic              DX_MemWrite,
  output logic              EX_stall,
  output logic              XM_MemtoReg,
  output logic              XM_RegWrite,
  output logic              XM_MemRead,
  output logic              XM_MemWrite,
  output logic [DATA_W-1:0] ALUout,
  output logic [RD_W-1:0]   XM_RD,
  output logic [DATA_W-1:0] XM_MD
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctl_t;

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc, r_mcand, r_mplier;
  ctl_t              r_mul_ctl;
  logic [RD_W-1:0]   r_mul_rd;
  logic [DATA_W-1:0] r_mul_md;
  ctl_t              r_xm_ctl;

  logic [DATA_W-1:0] w_op_b, w_alu, w_acc_next;
  ctl_t              w_dx_ctl;
  logic              w_is_mul, w_single, w_mul_last, w_stall;

  assign w_op_b     = DX_ALUSrc ? {{(DATA_W-16){DX_imm[15]}}, DX_imm} : DX_B;
  assign w_dx_ctl   = {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite};
  assign w_is_mul   = DX_valid && (DX_ALUctr == OP_MUL);
  assign w_single   = (r_state == S_IDLE) && DX_valid && (DX_ALUctr != OP_MUL);
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_LAST);
  assign w_acc_next = r_mcand[0] ? r_acc + r_mplier : r_acc;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_alu = '0;
    case (DX_ALUctr)
      OP_AND:  w_alu = A & w_op_b;
      OP_OR:   w_alu = A | w_op_b;
      OP_ADD:  w_alu = A + w_op_b;
      OP_SUB:  w_alu = A - w_op_b;
      OP_SLT:  w_alu = DATA_W'($signed(A) < $signed(w_op_b));
      OP_SLL:  w_alu = A << w_op_b[4:0];
      OP_SRL:  w_alu = A >> w_op_b[4:0];
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul) begin
          w_state_next = S_BUSY;
          w_stall      = 1'b1;
        end
      end
      S_BUSY: begin
        // Stall drops in the last step so the next instruction enters on the result edge.
        w_stall = !w_mul_last;
        if (w_mul_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign EX_stall = rst && w_stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_mul_ctl <= '0;
      r_mul_rd  <= '0;
      r_mul_md  <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_is_mul) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_mcand   <= A;
        r_mplier  <= w_op_b;
        r_mul_ctl <= w_dx_ctl;
        r_mul_rd  <= DX_RD;
        r_mul_md  <= DX_MD;
      end
    end else begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand >> 1;
      r_mplier <= r_mplier << 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // EX/MEM latch: single-cycle result, final product, or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xm_ctl <= '0;
      ALUout   <= '0;
      XM_RD    <= '0;
      XM_MD    <= '0;
    end else if (w_single) begin
      r_xm_ctl <= w_dx_ctl;
      ALUout   <= w_alu;
      XM_RD    <= DX_RD;
      XM_MD    <= DX_MD;
    end else if (w_mul_last) begin
      r_xm_ctl <= r_mul_ctl;
      ALUout   <= w_acc_next;
      XM_RD    <= r_mul_rd;
      XM_MD    <= r_mul_md;
    end else begin
      r_xm_ctl <= '0;
      ALUout   <= '0;
      XM_RD    <= '0;
      XM_MD    <= '0;
    end
  end

  assign {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite} = r_xm_ctl;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops, hand sequences for MUL and reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        DX_valid;
  logic [3:0]  DX_ALUctr;
  logic        DX_ALUSrc;
  logic [31:0] A, DX_B, DX_MD;
  logic [15:0] DX_imm;
  logic [4:0]  DX_RD;
  logic        DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite;
  logic        EX_stall;
  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [31:0] ALUout, XM_MD;
  logic [4:0]  XM_RD;
  logic [3:0]  xm_ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  execute_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .DX_valid(DX_valid), .DX_ALUctr(DX_ALUctr), .DX_ALUSrc(DX_ALUSrc),
    .A(A), .DX_B(DX_B), .DX_imm(DX_imm), .DX_MD(DX_MD), .DX_RD(DX_RD),
    .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite),
    .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
    .EX_stall(EX_stall),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
    .ALUout(ALUout), .XM_RD(XM_RD), .XM_MD(XM_MD)
  );

  always #5 clk = ~clk;

  assign xm_ctl = {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite};

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] md;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic [31:0] exp_alu;
    logic [4:0]  exp_rd;
    logic [31:0] exp_md;
    logic [3:0]  exp_ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                       input logic [31:0] md, input logic [4:0] rd, input logic [3:0] ctl);
    DX_valid  = v;
    DX_ALUctr = op;
    DX_ALUSrc = src;
    A         = a;
    DX_B      = b;
    DX_imm    = imm;
    DX_MD     = md;
    DX_RD     = rd;
    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite} = ctl;
  endtask

  task automatic bubble();
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 4'b0000);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_alu"},   ALUout,   64'h0);
    check({nm, "_rd"},    XM_RD,    64'h0);
    check({nm, "_md"},    XM_MD,    64'h0);
    check({nm, "_ctl"},   xm_ctl,   64'h0);
    check({nm, "_stall"}, EX_stall, 64'h0);
  endtask

  // Issues one MUL, counts stall cycles and leaked non-bubble outputs, then checks the product.
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [3:0] ctl, input bit follow_add);
    int n_stall = 0;
    int n_leak  = 0;
    drive(1'b1, 4'd8, 1'b0, a, b, 16'h0, 32'hCAFE_0000, 5'd9, ctl);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!EX_stall) break;
      n_stall++;
      step();
      if (xm_ctl != 4'b0000 || ALUout != 32'h0 || XM_RD != 5'd0) n_leak++;
    end
    check({nm, "_stall_cycles"}, n_stall, 64'd32);
    check({nm, "_bubbles"},      n_leak,  64'd0);
    step();
    check({nm, "_product"}, ALUout, exp);
    check({nm, "_rd"},      XM_RD,  64'd9);
    check({nm, "_md"},      XM_MD,  64'hCAFE_0000);
    check({nm, "_ctl"},     xm_ctl, ctl);
    if (follow_add) begin
      drive(1'b1, 4'd2, 1'b0, 32'd100, 32'd23, 16'h0, 32'h0, 5'd12, 4'b0100);
      #1;
      check({nm, "_add_nostall"}, EX_stall, 64'd0);
      step();
      check({nm, "_add_alu"}, ALUout, 64'd123);
      check({nm, "_add_rd"},  XM_RD,  64'd12);
      check({nm, "_add_ctl"}, xm_ctl, 64'b0100);
      bubble();
      step();
      check({nm, "_add_once"}, {xm_ctl, ALUout}, 64'h0);
    end else begin
      bubble();
      step();
      check({nm, "_after"}, {EX_stall, xm_ctl, ALUout}, 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int n_bad;
    //             v  op    src a              b              imm       md            rd     ctl      exp_alu        rd     md            ctl
    vecs.push_back('{1, 4'd2, 0, 32'd5,         32'd7,         16'h0,    32'h0,        5'd3, 4'b0100, 32'd12,        5'd3, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd6, 0, 32'd3,         32'd5,         16'h0,    32'h11,       5'd4, 4'b0100, 32'hFFFF_FFFE, 5'd4, 32'h11,       4'b0100});
    vecs.push_back('{1, 4'd7, 0, 32'hFFFF_FFFF, 32'd1,         16'h0,    32'h0,        5'd5, 4'b0100, 32'd1,         5'd5, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd7, 0, 32'h8000_0000, 32'h7FFF_FFFF, 16'h0,    32'h0,        5'd6, 4'b0100, 32'd1,         5'd6, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd7, 0, 32'd1,         32'hFFFF_FFFF, 16'h0,    32'h0,        5'd6, 4'b0100, 32'd0,         5'd6, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd3, 0, 32'd1,         32'd31,        16'h0,    32'h0,        5'd7, 4'b0100, 32'h8000_0000, 5'd7, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd4, 0, 32'h8000_0000, 32'h24,        16'h0,    32'h0,        5'd8, 4'b0100, 32'h0800_0000, 5'd8, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd2, 1, 32'd8,         32'h1234_5678, 16'hFFFC, 32'hDEAD,     5'd0, 4'b0001, 32'd4,         5'd0, 32'hDEAD,     4'b0001});
    vecs.push_back('{1, 4'd2, 1, 32'h100,       32'h0,         16'h0010, 32'h0,        5'd7, 4'b1110, 32'h110,       5'd7, 32'h0,        4'b1110});
    vecs.push_back('{1, 4'd0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0,    32'h0,        5'd1, 4'b0100, 32'hF000_F000, 5'd1, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd1, 0, 32'h0F00_0000, 32'h0000_00F0, 16'h0,    32'h0,        5'd2, 4'b0100, 32'h0F00_00F0, 5'd2, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd5, 0, 32'd3,         32'd4,         16'h0,    32'h0,        5'd2, 4'b0100, 32'd0,         5'd2, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd15,0, 32'd3,         32'd4,         16'h0,    32'h0,        5'd2, 4'b0100, 32'd0,         5'd2, 32'h0,        4'b0100});
    vecs.push_back('{0, 4'd2, 0, 32'd1,         32'd1,         16'h0,    32'h5,        5'd5, 4'b0100, 32'd0,         5'd0, 32'h0,        4'b0000});
    vecs.push_back('{1, 4'd6, 1, 32'd0,         32'd99,        16'h0001, 32'h0,        5'd3, 4'b0100, 32'hFFFF_FFFF, 5'd3, 32'h0,        4'b0100});
    vecs.push_back('{1, 4'd2, 0, 32'hFFFF_FFFF, 32'd2,         16'h0,    32'h0,        5'd4, 4'b0100, 32'd1,         5'd4, 32'h0,        4'b0100});

    // Power-on reset.
    rst = 1'b1;
    bubble();
    #2 rst = 1'b0;
    #1 check_zero("por");
    #9 rst = 1'b1;

    // Single-cycle ops.
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm,
            vecs[i].md, vecs[i].rd, vecs[i].ctl);
      #1;
      check($sformatf("v%0d_stall", i), EX_stall, 64'd0);
      step();
      check($sformatf("v%0d_alu", i), ALUout, vecs[i].exp_alu);
      check($sformatf("v%0d_rd", i),  XM_RD,  vecs[i].exp_rd);
      check($sformatf("v%0d_md", i),  XM_MD,  vecs[i].exp_md);
      check($sformatf("v%0d_ctl", i), xm_ctl, vecs[i].exp_ctl);
    end

    // Mid-cycle reset clears a live EX/MEM latch immediately.
    drive(1'b1, 4'd2, 1'b0, 32'd5, 32'd7, 16'h0, 32'h77, 5'd3, 4'b0100);
    step();
    check("pre_rst_alu", ALUout, 64'd12);
    #2 rst = 1'b0;
    #1 check_zero("mid_rst");
    bubble();
    #3 rst = 1'b1;
    step();

    // Multiplies.
    run_mul("mul_a", 32'h0001_0003, 32'h0000_0010, 32'h0010_0030, 4'b0100, 1'b0);
    run_mul("mul_b", 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 4'b0111, 1'b0);
    run_mul("mul_c", 32'd1234,      32'd5678,      32'd7006652,   4'b0001, 1'b1);

    // Reset at MUL cycle 10 aborts it; no product ever appears.
    drive(1'b1, 4'd8, 1'b0, 32'h0001_0003, 32'h10, 16'h0, 32'h0, 5'd9, 4'b0100);
    for (int i = 0; i < 10; i++) step();
    check("mul10_stall_pre", EX_stall, 64'd1);
    #2 rst = 1'b0;
    #1 check_zero("mul10_rst");
    bubble();
    step();
    #3 rst = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ALUout != 32'h0 || xm_ctl != 4'b0000 || EX_stall) n_bad++;
    end
    check("mul10_no_product", n_bad, 64'd0);
    drive(1'b1, 4'd2, 1'b0, 32'd5, 32'd7, 16'h0, 32'h0, 5'd3, 4'b0100);
    step();
    check("post_rst_add_alu", ALUout, 64'd12);
    check("post_rst_add_ctl", xm_ctl, 64'b0100);
    check("post_rst_add_rd",  XM_RD,  64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
